// File: rtl/dm_bus_responder_pkg.sv
// rtl/dm_bus_responder_pkg.sv - shared DMType codes, FSM states and bus-error constant
// DMType values must stay in step with the CPU control-unit encoding.
package dm_bus_responder_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF_S = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE_S = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM_WAIT,
    ST_IO_WAIT,
    ST_DONE
  } state_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

  function automatic logic dm_misaligned(input logic [2:0] dm_type, input logic [1:0] lo);
    case (dm_type)
      DM_HALF_S, DM_HALF_U: return lo[0];
      DM_BYTE_S, DM_BYTE_U: return 1'b0;
      default:              return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - store lane steering and load lane extraction/extension
// Purely combinational so a future cache can share it.
module dm_lane_align
  import dm_bus_responder_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  dm_type_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] ld_data_o
);

  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  always_comb begin
    ld_half   = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    ld_byte   = ld_word_i[{addr_lo_i, 3'b000} +: 8];
    st_data_o = st_data_i;
    st_be_o   = 4'b1111;
    ld_data_o = ld_word_i;
    case (dm_type_i)
      DM_HALF_S, DM_HALF_U: begin
        st_data_o = {2{st_data_i[15:0]}};
        st_be_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        ld_data_o = (dm_type_i == DM_HALF_S) ? {{16{ld_half[15]}}, ld_half} : {16'h0000, ld_half};
      end
      DM_BYTE_S, DM_BYTE_U: begin
        st_data_o = {4{st_data_i[7:0]}};
        st_be_o   = 4'b0001 << addr_lo_i;
        ld_data_o = (dm_type_i == DM_BYTE_S) ? {{24{ld_byte[7]}}, ld_byte} : {24'h000000, ld_byte};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_bus_responder.sv
// rtl/dm_bus_responder.sv - CPU data-port responder: wait-stated word RAM plus req/ack peripheral port
// Optional BUS_TIMEOUT_EN aborts a peripheral access that is not acked within IO_TIMEOUT cycles.
module dm_bus_responder
  import dm_bus_responder_pkg::*;
#(
  parameter int          RAM_DEPTH   = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [3:0]  IO_NIBBLE   = 4'hF,
  parameter int          IO_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mio,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] rdata,
  output logic        mio_ready,
  output logic        bus_err,
  output logic        io_req,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_be,
  input  logic [31:0] io_rdata,
  input  logic        io_ack
);

  localparam int IW = $clog2(RAM_DEPTH);

  if (RAM_DEPTH < 2 || (RAM_DEPTH & (RAM_DEPTH - 1)) != 0 || WAIT_CYCLES < 0 ||
      WAIT_CYCLES > 15 || IO_TIMEOUT < 1) begin : g_param_check
    $error("dm_bus_responder: illegal parameter value");
  end

  logic [31:0] mem [RAM_DEPTH];

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [2:0]    dm_type_q;
  logic [1:0]    lane_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   st_data_q;
  logic [3:0]    st_be_q;
  logic [31:0]   rdata_q;
  logic          mio_ready_q, bus_err_q;
  logic          io_req_q, io_we_q;
  logic [31:0]   io_addr_q, io_wdata_q;
  logic [3:0]    io_be_q;
`ifdef BUS_TIMEOUT_EN
  localparam int TW = ($clog2(IO_TIMEOUT + 1) > 8) ? $clog2(IO_TIMEOUT + 1) : 8;
  logic [TW-1:0] to_cnt_q;
`endif

  logic        misaligned, ram_fire;
  logic [1:0]  al_lane;
  logic [2:0]  al_type;
  logic [31:0] al_word, al_st_data, al_ld_data;
  logic [3:0]  al_be;

  // In IDLE the aligner steers the live request; afterwards it extracts from the latched one.
  assign al_lane    = (state_q == ST_IDLE) ? addr[1:0] : lane_q;
  assign al_type    = (state_q == ST_IDLE) ? dm_type   : dm_type_q;
  assign al_word    = (state_q == ST_IO_WAIT) ? io_rdata : mem[idx_q];
  assign misaligned = dm_misaligned(dm_type, addr[1:0]);
  assign ram_fire   = (state_q == ST_RAM_WAIT) && (cnt_q == 4'd0);

  dm_lane_align u_align (
    .addr_lo_i (al_lane),
    .dm_type_i (al_type),
    .st_data_i (wdata),
    .ld_word_i (al_word),
    .st_data_o (al_st_data),
    .st_be_o   (al_be),
    .ld_data_o (al_ld_data)
  );

  always_ff @(posedge clk) begin
    if (ram_fire && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be_q[b]) mem[idx_q][8*b +: 8] <= st_data_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      dm_type_q   <= DM_WORD;
      lane_q      <= 2'b00;
      idx_q       <= '0;
      st_data_q   <= 32'h0;
      st_be_q     <= 4'h0;
      rdata_q     <= 32'h0;
      mio_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      io_req_q    <= 1'b0;
      io_we_q     <= 1'b0;
      io_addr_q   <= 32'h0;
      io_wdata_q  <= 32'h0;
      io_be_q     <= 4'h0;
`ifdef BUS_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      mio_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_mio) begin
            we_q      <= mem_w;
            dm_type_q <= dm_type;
            lane_q    <= addr[1:0];
            idx_q     <= addr[IW+1:2];
            st_data_q <= al_st_data;
            st_be_q   <= al_be;
            rdata_q   <= 32'h0;
            bus_err_q <= 1'b0;
            if (misaligned) begin
              state_q     <= ST_DONE;
              mio_ready_q <= 1'b1;
              bus_err_q   <= 1'b1;
            end else if (addr[31:28] == IO_NIBBLE) begin
              state_q    <= ST_IO_WAIT;
              io_req_q   <= 1'b1;
              io_we_q    <= mem_w;
              io_addr_q  <= {addr[31:2], 2'b00};
              io_wdata_q <= al_st_data;
              io_be_q    <= al_be;
`ifdef BUS_TIMEOUT_EN
              to_cnt_q   <= '0;
`endif
            end else begin
              state_q <= ST_RAM_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_RAM_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q     <= ST_DONE;
            mio_ready_q <= 1'b1;
            rdata_q     <= we_q ? 32'h0 : al_ld_data;
          end
        end
        ST_IO_WAIT: begin
          if (io_ack) begin
            state_q     <= ST_DONE;
            io_req_q    <= 1'b0;
            mio_ready_q <= 1'b1;
            rdata_q     <= we_q ? 32'h0 : al_ld_data;
          end
`ifdef BUS_TIMEOUT_EN
          else if (to_cnt_q == TW'(IO_TIMEOUT - 1)) begin
            state_q     <= ST_DONE;
            io_req_q    <= 1'b0;
            mio_ready_q <= 1'b1;
            bus_err_q   <= 1'b1;
            rdata_q     <= BUS_ERR_DATA;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          rdata_q   <= 32'h0;
          bus_err_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign mio_ready = mio_ready_q;
  assign bus_err   = bus_err_q;
  assign io_req    = io_req_q;
  assign io_we     = io_we_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;
  assign io_be     = io_be_q;

endmodule

// File: doc/dm_bus_responder.md
Name: dm_bus_responder

Overview:
Memory-side responder for the CPU data port: accepts load/store requests (address, write data, write strobe, DMType), performs byte-lane steering and load extension, and answers with read data plus a one-cycle ready pulse. Addresses decode either to an internal word RAM with programmable wait states or to an external peripheral port with a req/ack handshake. Sits between the pipeline's data-memory outputs and the RAM/MMIO subsystem.

Parameters:
RAM_DEPTH, 1024, number of 32-bit RAM words (power of 2)
WAIT_CYCLES, 1, extra RAM wait states (0..15)
IO_NIBBLE, 4'hF, addr[31:28] value selecting the peripheral port
IO_TIMEOUT, 255, io_ack wait limit in cycles (used only with BUS_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_mio  in  1  request valid; held with other request inputs stable until mio_ready
mem_w  in  1  1 = store, 0 = load
addr  in  32  byte address
wdata  in  32  store data, right-justified
dm_type  in  3  access size/sign (DMType encoding)
rdata  out  32  load result, extended; valid only while mio_ready=1
mio_ready  out  1  one-cycle completion pulse
bus_err  out  1  high with mio_ready when the access was aborted
io_req  out  1  peripheral request, held until io_ack
io_we  out  1  peripheral write
io_addr  out  32  word-aligned peripheral address
io_wdata  out  32  lane-steered write data
io_be  out  4  byte enables
io_rdata  in  32  raw peripheral word
io_ack  in  1  peripheral completion (one cycle)

Behaviour:
- Reset: state IDLE; rdata=0, mio_ready=0, bus_err=0, io_req=0, io_we=0, io_addr=0, io_wdata=0, io_be=0. RAM contents not reset. Reset mid-access abandons it silently; no write occurs.
- DMType: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 treated as word.
- States: IDLE, RAM_WAIT, IO_WAIT, DONE.
- IDLE: on cpu_mio=1 latch all request inputs. Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE with bus_err, no write. addr[31:28]==IO_NIBBLE -> IO_WAIT, assert io_req/io_we/io_addr/io_wdata/io_be next cycle. Otherwise -> RAM_WAIT, counter=WAIT_CYCLES.
- RAM_WAIT: counter!=0 -> decrement; counter==0 -> perform access at this edge, go DONE. mio_ready first high WAIT_CYCLES+2 cycles after the cycle cpu_mio is sampled (i.e. WAIT_CYCLES+1 edges after acceptance).
- RAM index = addr[log2(RAM_DEPTH)+1:2]; upper bits ignored (wrap modulo depth).
- Store steering: byte -> wdata[7:0] replicated, be = 1<<addr[1:0]; half -> wdata[15:0] replicated, be = addr[1]?1100:0011; word -> be=1111. Only enabled lanes written.
- Load extraction: select lane by addr[1:0]/addr[1], sign- or zero-extend per dm_type.
- IO_WAIT: outputs held until io_ack; on io_ack drop io_req, capture io_rdata, go DONE. io_ack outside IO_WAIT ignored.
- DONE: mio_ready=1 for exactly one cycle; rdata valid (0 for stores and errors); -> IDLE. cpu_mio still high in next IDLE cycle is a new request (back-to-back allowed, one idle cycle between).
- Without timeout, IO_WAIT waits indefinitely.

Optional Feature:
BUS_TIMEOUT_EN: defined -> 8-bit-or-wider counter in IO_WAIT; if io_ack absent for IO_TIMEOUT cycles, drop io_req, go DONE with bus_err=1, rdata=32'hDEADBEEF. Undefined -> no counter, no timeout path; bus_err only from misalignment.

Decomposition:
- Shared package/define file: DMType codes (shared with CPU control encoding), state encodings, DEADBEEF error constant.
- One sub-module: dm_lane_align (combinational store steering -> data/be, load extraction -> extended word); reused by any future cache.

Test Plan:
- WAIT_CYCLES=1: store word 0x12345678 to 0x0000_0010, load word back -> rdata=0x12345678, mio_ready 3 cycles after request sampled, one cycle wide.
- Store byte 0x80 to 0x13, load byte signed 0x13 -> 0xFFFFFF80; byte unsigned -> 0x00000080; load word 0x10 -> 0x80345678.
- Load half signed at 0x11 -> mio_ready with bus_err=1, rdata=0, RAM unchanged.
- Load word 0xF000_0004, peripheral acks after 5 cycles with 0xCAFEF00D -> io_addr=0xF0000004, io_be=1111, io_req held 5 cycles, rdata=0xCAFEF00D.
- BUS_TIMEOUT_EN, IO_TIMEOUT=8, no io_ack -> io_req drops, bus_err=1, rdata=0xDEADBEEF.
- Assert reset during RAM_WAIT of store 0xAAAAAAAA to 0x20 -> outputs zero immediately, later load 0x20 returns prior value.
